loop_idx_gen: RTL

//  Hardware loop-index sequencer. Emits the index stream of
//  for(i=init; (i<hi)&&(i>lo); i+=step) over a valid/ready port.

---
 rtl/loop_idx_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/loop_idx_gen.sv
// ============================================================================
// Module   : loop_idx_gen
// Purpose  : Hardware loop-index sequencer. Emits the index stream of
//            for(i=init; (i<hi)&&(i>lo); i+=step) on a valid/ready port, with
//            an iteration bound and signed-overflow abort.
// Options  : LOOP_IDX_GEN_COUNT_EN exposes the accepted-index count as iter_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_idx_gen #(
  parameter int IDX_W    = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] init_i,
  input  logic [IDX_W-1:0] lo_i,
  input  logic [IDX_W-1:0] hi_i,
  input  logic [IDX_W-1:0] step_i,
  output logic             busy_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             done_o,
`ifdef LOOP_IDX_GEN_COUNT_EN
  output logic [CNT_W-1:0] iter_cnt_o,
`endif
  output logic             abort_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] lo;
  logic [IDX_W-1:0] hi;
  logic [IDX_W-1:0] step;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             idx_valid;
  logic             done;
  logic             abort;

  logic             in_range;
  logic [IDX_W-1:0] idx_sum;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_iter;
  logic             handshake;

  assign in_range  = ($signed(idx) < $signed(hi)) && ($signed(idx) > $signed(lo));
  assign idx_sum   = idx + step;
  // Signed overflow: operands share a sign and the wrapped sum flips it.
  assign sum_ovf   = (idx[IDX_W-1] == step[IDX_W-1]) && (idx_sum[IDX_W-1] != idx[IDX_W-1]);
  assign cnt_inc   = cnt + 1'b1;
  assign last_iter = (cnt_inc == MAX_CNT);
  assign handshake = idx_valid & idx_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      lo        <= '0;
      hi        <= '0;
      step      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      idx_valid <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            idx   <= init_i;
            lo    <= lo_i;
            hi    <= hi_i;
            step  <= step_i;
            cnt   <= '0;
            abort <= 1'b0;
            busy  <= 1'b1;
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (in_range) begin
            idx_valid <= 1'b1;
            state     <= ST_EMIT;
          end else begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_EMIT: begin
          if (handshake) begin
            idx_valid <= 1'b0;
            cnt       <= cnt_inc;
            idx       <= idx_sum;
            // Iteration bound takes priority; both end the run the same way.
            if (last_iter || sum_ovf) begin
              abort <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_CHECK;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          idx_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy;
  assign idx_valid_o = idx_valid;
  assign idx_o       = idx;
  assign done_o      = done;
  assign abort_o     = abort;

`ifdef LOOP_IDX_GEN_COUNT_EN
  assign iter_cnt_o  = cnt;
`endif

endmodule

`default_nettype wire
